// File: rtl/lsu.sv
// Load/store unit: byte-serial memory access between ex_mem and mem_wb.
// Optional feature: define LSU_ALIGN_CHECK_EN to drop misaligned halfword/word
// accesses with a one-cycle misalign_o pulse instead of running them bytewise.
//
// Memory handshake: while mem_req_o is high, mem_addr_o, mem_wr_o and
// mem_wdata_o stay stable until mem_ack_i; one byte completes on every rising
// edge where mem_req_o && mem_ack_i, and mem_rdata_i is sampled on that edge.

`ifndef LSU_SHARED_DEFINES
`define LSU_SHARED_DEFINES
// Standalone copies of the shared pipeline defines.
`define OptBus   3:0
`define OptNOP   4'd0
`define OptLB    4'd1
`define OptLH    4'd2
`define OptLW    4'd3
`define OptLBU   4'd4
`define OptLHU   4'd5
`define OptSB    4'd6
`define OptSH    4'd7
`define OptSW    4'd8
`define OpcLoad  7'b0000011
`define OpcStore 7'b0100011
`endif

module lsu (
    input  logic           clk,
    input  logic           rst,
    input  logic [6:0]     opcode_i,
    input  logic [`OptBus] opt_i,
    input  logic           we_i,
    input  logic [4:0]     waddr_i,
    input  logic [31:0]    alu_i,
    input  logic [31:0]    rdata2_i,
    output logic           we_o,
    output logic [4:0]     waddr_o,
    output logic [31:0]    wdata_o,
    output logic           stall_o,
    output logic           mem_req_o,
    output logic           mem_wr_o,
    output logic [31:0]    mem_addr_o,
    output logic [7:0]     mem_wdata_o,
    input  logic [7:0]     mem_rdata_i,
    input  logic           mem_ack_i,
    output logic           misalign_o,
    output logic [1:0]     fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [`OptBus] opt_q;
    logic [4:0]     waddr_q;
    logic           we_q;
    logic [31:0]    base_q;
    logic [31:0]    sdata_q;
    logic [31:0]    ldata_q;
    logic [1:0]     idx_q;
    logic [2:0]     cnt_q;

    logic           is_load, is_store, is_mem, misalign;
    logic [2:0]     cnt_d;
    logic           store_q, last_byte;
    logic [31:0]    load_ext;

    // Decode the incoming ex_mem instruction and its byte count.
    always_comb begin
        is_load  = (opcode_i == `OpcLoad) &&
                   (opt_i inside {`OptLB, `OptLH, `OptLW, `OptLBU, `OptLHU});
        is_store = (opcode_i == `OpcStore) &&
                   (opt_i inside {`OptSB, `OptSH, `OptSW});
        is_mem   = is_load || is_store;
        case (opt_i)
            `OptLB, `OptLBU, `OptSB: cnt_d = 3'd1;
            `OptLH, `OptLHU, `OptSH: cnt_d = 3'd2;
            default:                 cnt_d = 3'd4;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        misalign = is_mem && (((cnt_d == 3'd2) && alu_i[0]) ||
                              ((cnt_d == 3'd4) && (alu_i[1:0] != 2'b00)));
`else
        misalign = 1'b0;
`endif
    end

    // Properties of the latched transaction.
    always_comb begin
        store_q   = opt_q inside {`OptSB, `OptSH, `OptSW};
        last_byte = (({1'b0, idx_q}) + 3'd1) == cnt_q;
        case (opt_q)
            `OptLB:  load_ext = {{24{ldata_q[7]}}, ldata_q[7:0]};
            `OptLH:  load_ext = {{16{ldata_q[15]}}, ldata_q[15:0]};
            `OptLBU: load_ext = {24'd0, ldata_q[7:0]};
            `OptLHU: load_ext = {16'd0, ldata_q[15:0]};
            default: load_ext = ldata_q;
        endcase
    end

    // Next-state logic: IDLE -> ACCESS per accepted op, DONE after the last ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_mem && !misalign) state_d = ACCESS;
            ACCESS:  if (mem_ack_i && last_byte) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus transaction latch and byte-lane assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opt_q   <= `OptNOP;
            waddr_q <= 5'd0;
            we_q    <= 1'b0;
            base_q  <= 32'd0;
            sdata_q <= 32'd0;
            ldata_q <= 32'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_mem && !misalign) begin
                        opt_q   <= opt_i;
                        waddr_q <= waddr_i;
                        we_q    <= we_i;
                        base_q  <= alu_i;
                        sdata_q <= rdata2_i;
                        cnt_q   <= cnt_d;
                        idx_q   <= 2'd0;
                        ldata_q <= 32'd0;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        if (!store_q) ldata_q[{idx_q, 3'b000} +: 8] <= mem_rdata_i;
                        idx_q <= idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; everything is held at zero while rst is high.
    always_comb begin
        we_o        = 1'b0;
        waddr_o     = 5'd0;
        wdata_o     = 32'd0;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 8'd0;
        misalign_o  = 1'b0;
        fsm_state_o = state_q;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (misalign) begin
                        misalign_o = 1'b1;
                    end else if (is_mem) begin
                        stall_o = 1'b1;
                    end else begin
                        we_o    = we_i;
                        waddr_o = waddr_i;
                        wdata_o = alu_i;
                    end
                end
                ACCESS: begin
                    stall_o     = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_wr_o    = store_q;
                    mem_addr_o  = base_q + {30'd0, idx_q};
                    mem_wdata_o = sdata_q[{idx_q, 3'b000} +: 8];
                end
                DONE: begin
                    waddr_o = waddr_q;
                    if (!store_q) begin
                        we_o    = we_q;
                        wdata_o = load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus a randomized mix checked against
// a byte-addressed memory model and a queue of expected writeback values.
module tb_lsu;

    localparam logic [3:0] O_NOP = 4'd0, O_LB = 4'd1, O_LH = 4'd2, O_LW = 4'd3,
                           O_LBU = 4'd4, O_LHU = 4'd5, O_SB = 4'd6, O_SH = 4'd7,
                           O_SW = 4'd8, O_ADD = 4'd9;
    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011;

    logic        clk, rst;
    logic [6:0]  opcode_i;
    logic [3:0]  opt_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] alu_i, rdata2_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stall_o, mem_req_o, mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o, mem_rdata_i;
    logic        mem_ack_i, misalign_o;
    logic [1:0]  fsm_state_o;

    lsu dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .opt_i(opt_i), .we_i(we_i),
        .waddr_i(waddr_i), .alu_i(alu_i), .rdata2_i(rdata2_i), .we_o(we_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .misalign_o(misalign_o),
        .fsm_state_o(fsm_state_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]  mem_model [logic [31:0]];
    logic [31:0] exp_q [$];

    // Reference model
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic int nbytes(input logic [3:0] o);
        case (o)
            O_LB, O_LBU, O_SB: return 1;
            O_LH, O_LHU, O_SH: return 2;
            default:           return 4;
        endcase
    endfunction

    function automatic bit is_st(input logic [3:0] o);
        return (o == O_SB) || (o == O_SH) || (o == O_SW);
    endfunction

    function automatic logic [31:0] load_val(input logic [3:0] o, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nbytes(o); i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        case (o)
            O_LB:    return {{24{v[7]}}, v[7:0]};
            O_LH:    return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic bit misaligned(input logic [3:0] o, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        if (nbytes(o) == 2) return a[0];
        if (nbytes(o) == 4) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return (o == O_NOP) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Driver tasks
    task automatic drive_nop();
        opcode_i = OPC_IMM; opt_i = O_NOP; we_i = 1'b0; waddr_i = 5'd0;
        alu_i = 32'd0; rdata2_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 8'd0;
    endtask

    // Runs one load/store; gap >= 0 means first byte acked at once and then
    // 'gap' idle cycles between acks, gap < 0 means random 0..2 wait cycles.
    task automatic do_mem(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] wa, input logic w, input int gap,
                          output int sc);
        int n, k, left;
        bit st;
        logic [31:0] exp_wb;
        n = nbytes(o); st = is_st(o); sc = 0;
        @(posedge clk); #1;
        opcode_i = st ? OPC_STORE : OPC_LOAD; opt_i = o; we_i = w; waddr_i = wa;
        alu_i = a; rdata2_i = sd;
        mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = 8'($urandom);
        if (misaligned(o, a)) begin
            @(negedge clk);
            n_checks++;
            if ({misalign_o, stall_o, mem_req_o, we_o} !== 4'b1000)
                $display("FAIL misalign_flags: got mis/stall/req/we=%b want 1000",
                         {misalign_o, stall_o, mem_req_o, we_o});
            else n_pass++;
            return;
        end
        exp_q.push_back(st ? 32'd0 : load_val(o, a));
        @(negedge clk);
        if (stall_o) sc++;
        n_checks++;
        if ({stall_o, mem_req_o, we_o, misalign_o} !== 4'b1000)
            $display("FAIL issue_flags: got stall/req/we/mis=%b want 1000",
                     {stall_o, mem_req_o, we_o, misalign_o});
        else n_pass++;
        k = 0;
        left = (gap < 0) ? int'($urandom_range(0, 2)) : 0;
        while (k < n) begin
            @(negedge clk);
            if (stall_o) sc++;
            n_checks++;
            if ({stall_o, mem_req_o, mem_wr_o, we_o} !== {1'b1, 1'b1, st, 1'b0})
                $display("FAIL access_flags: got stall/req/wr/we=%b want %b",
                         {stall_o, mem_req_o, mem_wr_o, we_o}, {1'b1, 1'b1, st, 1'b0});
            else n_pass++;
            n_checks++;
            if (mem_addr_o !== a + 32'(k))
                $display("FAIL access_addr: got %h want %h", mem_addr_o, a + 32'(k));
            else n_pass++;
            if (st) begin
                n_checks++;
                if (mem_wdata_o !== sd[8*k +: 8])
                    $display("FAIL access_wdata: got %h want %h", mem_wdata_o, sd[8*k +: 8]);
                else n_pass++;
            end
            if (left == 0) begin
                mem_ack_i = 1'b1;
                if (st) begin
                    mem_model[a + 32'(k)] = sd[8*k +: 8];
                    mem_rdata_i = 8'($urandom);
                end else begin
                    mem_rdata_i = rd_byte(a + 32'(k));
                end
                k++;
                left = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            end else begin
                mem_ack_i = 1'b0; mem_rdata_i = 8'($urandom); left--;
            end
        end
        @(negedge clk);
        if (stall_o) sc++;
        exp_wb = exp_q.pop_front();
        n_checks++;
        if ({stall_o, mem_req_o, we_o} !== {1'b0, 1'b0, (st ? 1'b0 : w)})
            $display("FAIL done_flags: got stall/req/we=%b want %b",
                     {stall_o, mem_req_o, we_o}, {1'b0, 1'b0, (st ? 1'b0 : w)});
        else n_pass++;
        n_checks++;
        if (wdata_o !== exp_wb)
            $display("FAIL done_wdata: got %h want %h", wdata_o, exp_wb);
        else n_pass++;
        n_checks++;
        if (waddr_o !== wa)
            $display("FAIL done_waddr: got %0d want %0d", waddr_o, wa);
        else n_pass++;
        mem_ack_i = 1'($urandom_range(0, 1));
    endtask

    task automatic pass_through(input logic [3:0] o);
        logic        w;
        logic [4:0]  wa;
        logic [31:0] v;
        w = 1'($urandom_range(0, 1)); wa = 5'($urandom); v = $urandom;
        @(posedge clk); #1;
        opcode_i = (o == O_NOP) ? OPC_IMM : OPC_OP; opt_i = o; we_i = w;
        waddr_i = wa; alu_i = v; rdata2_i = $urandom; mem_ack_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_checks++;
        if ({we_o, waddr_o, wdata_o} !== {w, wa, v})
            $display("FAIL pass_data: got we=%b waddr=%0d wdata=%h want we=%b waddr=%0d wdata=%h",
                     we_o, waddr_o, wdata_o, w, wa, v);
        else n_pass++;
        n_checks++;
        if ({stall_o, mem_req_o, misalign_o} !== 3'b000)
            $display("FAIL pass_flags: got stall/req/mis=%b want 000",
                     {stall_o, mem_req_o, misalign_o});
        else n_pass++;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        opcode_i = OPC_LOAD; opt_i = O_LW; we_i = 1'b1; waddr_i = 5'd9;
        alu_i = 32'h100; rdata2_i = 32'h1234_5678; mem_ack_i = 1'b1; mem_rdata_i = 8'h55;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({we_o, waddr_o, wdata_o, stall_o, mem_req_o, mem_wr_o, mem_addr_o,
             mem_wdata_o, misalign_o} !== 82'd0)
            $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h stall=%b req=%b wr=%b addr=%h wd=%h mis=%b want all 0",
                     we_o, waddr_o, wdata_o, stall_o, mem_req_o, mem_wr_o, mem_addr_o,
                     mem_wdata_o, misalign_o);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        n_checks++;
        if ({stall_o, mem_req_o} !== 2'b00)
            $display("FAIL reset_idle: got stall/req=%b want 00", {stall_o, mem_req_o});
        else n_pass++;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 5; i++) pass_through(O_ADD);
        pass_through(O_NOP);
    endtask

    task automatic test_lw();
        int sc;
        mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
        do_mem(O_LW, 32'h100, 32'h0, 5'd7, 1'b1, 0, sc);
        n_checks++;
        if (sc != 5) $display("FAIL lw_stall_cycles: got %0d want 5", sc);
        else n_pass++;
    endtask

    task automatic test_sh();
        int sc;
        do_mem(O_SH, 32'h200, 32'hDEAD_BEEF, 5'd3, 1'b1, 0, sc);
        n_checks++;
        if (sc != 3) $display("FAIL sh_stall_cycles: got %0d want 3", sc);
        else n_pass++;
        do_mem(O_LHU, 32'h200, 32'h0, 5'd4, 1'b1, 0, sc);
    endtask

    task automatic test_sign_ext();
        int sc;
        mem_model[32'h300] = 8'h80;
        mem_model[32'h310] = 8'h34; mem_model[32'h311] = 8'h92;
        do_mem(O_LB,  32'h300, 32'h0, 5'd1, 1'b1, 0, sc);
        do_mem(O_LBU, 32'h300, 32'h0, 5'd2, 1'b1, 0, sc);
        do_mem(O_LH,  32'h310, 32'h0, 5'd5, 1'b1, 0, sc);
        do_mem(O_LHU, 32'h310, 32'h0, 5'd6, 1'b0, 0, sc);
    endtask

    task automatic test_gaps();
        int sc;
        do_mem(O_LW, 32'h400, 32'h0, 5'd11, 1'b1, 3, sc);
        n_checks++;
        if (sc != 14) $display("FAIL gap_stall_cycles: got %0d want 14", sc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic        w;
        logic [4:0]  wa;
        logic [31:0] v;
        @(posedge clk); #1;
        opcode_i = OPC_LOAD; opt_i = O_LW; we_i = 1'b1; waddr_i = 5'd12;
        alu_i = 32'h500; mem_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 8'h11;
        @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 8'h22;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h502})
            $display("FAIL midreset_addr: got req=%b addr=%h want req=1 addr=00000502",
                     mem_req_o, mem_addr_o);
        else n_pass++;
        rst = 1'b1; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        w = 1'b1; wa = 5'd13; v = $urandom;
        opcode_i = OPC_OP; opt_i = O_ADD; we_i = w; waddr_i = wa; alu_i = v;
        @(negedge clk);
        n_checks++;
        if ({stall_o, mem_req_o} !== 2'b00)
            $display("FAIL midreset_idle: got stall/req=%b want 00", {stall_o, mem_req_o});
        else n_pass++;
        n_checks++;
        if ({we_o, waddr_o, wdata_o} !== {w, wa, v})
            $display("FAIL midreset_add: got we=%b waddr=%0d wdata=%h want we=%b waddr=%0d wdata=%h",
                     we_o, waddr_o, wdata_o, w, wa, v);
        else n_pass++;
    endtask

    task automatic test_align();
        int sc;
`ifdef LSU_ALIGN_CHECK_EN
        do_mem(O_LW, 32'h102, 32'h0, 5'd8, 1'b1, 0, sc);
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        n_checks++;
        if ({misalign_o, mem_req_o, stall_o} !== 3'b000)
            $display("FAIL misalign_pulse: got mis/req/stall=%b want 000",
                     {misalign_o, mem_req_o, stall_o});
        else n_pass++;
        do_mem(O_SH, 32'h201, 32'h1234_5678, 5'd8, 1'b0, 0, sc);
        do_mem(O_LH, 32'hFFFF_FFFE, 32'h0, 5'd9, 1'b1, 0, sc);
`else
        do_mem(O_LW, 32'h102, 32'h0, 5'd8, 1'b1, 0, sc);
        do_mem(O_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, 5'd9, 1'b0, 0, sc);
        do_mem(O_LW, 32'hFFFF_FFFE, 32'h0, 5'd10, 1'b1, 0, sc);
`endif
        n_checks++;
        if (misalign_o !== 1'b0)
            $display("FAIL misalign_idle: got %b want 0", misalign_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] ops [8];
        logic [3:0] o;
        logic [31:0] a;
        int sc;
        ops = '{O_LB, O_LH, O_LW, O_LBU, O_LHU, O_SB, O_SH, O_SW};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) >= 8) begin
                pass_through(O_ADD);
            end else begin
                o = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                else a = 32'h1000 + 32'($urandom_range(0, 15));
                do_mem(o, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), -1, sc);
            end
        end
    endtask

    // Sequence and final report
    initial begin
        drive_nop();
        test_reset();
        test_passthrough();
        test_lw();
        test_sh();
        test_sign_ext();
        test_gaps();
        test_reset_mid();
        test_align();
        test_random();
        @(posedge clk); #1;
        drive_nop();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
